// File: rtl/ins_loader_pkg.sv
// Shared types and widths for the boot-time
// instruction loader.
package ins_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } ld_state_e;

endpackage

// File: rtl/ins_loader_if.sv
// Byte-stream input and instruction-memory
// write port of the loader.
interface ins_loader_if;
  import ins_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ins_loader_byte_packer.sv
// Packs four accepted bytes big-endian into a
// word and flags the byte that completes it.
module ins_loader_byte_packer
  import ins_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_done
);

  logic [1:0]  r_idx;
  logic [23:0] r_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_sr  <= '0;
    end else if (i_en) begin
      r_idx <= r_idx + 2'd1;
      r_sr  <= {r_sr[15:0], i_byte};
    end
  end

  // Word is complete combinationally with byte 3
  assign o_word = {r_sr, i_byte};
  assign o_done = i_en && (r_idx == 2'd3);

endmodule

// File: rtl/ins_loader.sv
// Boot loader: parses length, data words and
// checksum, writes imem, then releases the core.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0,
  parameter int unsigned       MAX_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  ins_loader_if.slave      bus,
  output logic             core_run,
  output logic             load_err,
  output logic             busy,
  output logic [LEN_W-1:0] words_loaded
);

  ld_state_e         r_state;
  logic [BYTE_W-1:0] r_len_hi;
  logic [BYTE_W-1:0] r_xor;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_run;
  logic              r_err;
  logic              r_busy;

  logic              w_acc;
  logic              w_pack_en;
  logic [LEN_W-1:0]  w_len;
  logic              w_too_big;
  logic [WORD_W-1:0] w_word;
  logic              w_done;
  logic              w_last;

  assign w_acc     = bus.in_valid && bus.in_ready;
  assign w_pack_en = w_acc && (r_state == S_DATA);
  assign w_len     = {r_len_hi, bus.in_data};
  assign w_too_big = 32'(w_len) > MAX_WORDS;
  // r_cnt still holds this word's index
  assign w_last    = w_done
                  && (r_cnt + 16'd1 == r_len);

  ins_loader_byte_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_pack_en),
    .i_byte (bus.in_data),
    .o_word (w_word),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_len_hi <= '0;
      r_xor    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= BASE_ADDR;
      r_wdata  <= '0;
      r_run    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_we <= w_done;
      if (w_done) begin
        r_addr  <= BASE_ADDR
                 + {14'd0, r_cnt, 2'b00};
        r_wdata <= w_word;
        r_cnt   <= r_cnt + 16'd1;
      end
      if (w_acc) begin
        unique case (r_state)
          S_IDLE: begin
            r_len_hi <= bus.in_data;
            r_busy   <= 1'b1;
            r_state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_len <= w_len;
            if (w_len == '0) begin
              r_state <= S_CHK;
            end else if (w_too_big) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_xor <= r_xor ^ bus.in_data;
            if (w_last) r_state <= S_CHK;
          end
          S_CHK: begin
            r_busy <= 1'b0;
            if (bus.in_data == r_xor) begin
              r_state <= S_DONE;
              r_run   <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready = rst_n && (r_state inside
    {S_IDLE, S_LEN_LO, S_DATA, S_CHK});
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign core_run      = r_run;
  assign load_err      = r_err;
  assign busy          = r_busy;
  assign words_loaded  = r_cnt;

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: fixed
// scenarios plus random streams vs a model.
module tb_ins_loader;
  import ins_loader_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             core_run;
  logic             load_err;
  logic             busy;
  logic [LEN_W-1:0] words_loaded;

  ins_loader_if bus ();

  ins_loader #(
    .BASE_ADDR (32'h0),
    .MAX_WORDS (256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .core_run     (core_run),
    .load_err     (load_err),
    .busy         (busy),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim[$];
  int          acc_n;
  time         t_acc, t_run, t_err;
  logic [31:0] got_a[$], got_d[$];
  int          got_at[$];
  logic [31:0] ex_a[$], ex_d[$];
  int          ex_at[$];
  bit          ex_run, ex_err;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_a.push_back(bus.mem_addr);
      got_d.push_back(bus.mem_wdata);
      got_at.push_back(acc_n);
    end
    if (core_run === 1'b1 && t_run == 0)
      t_run = $time;
    if (load_err === 1'b1 && t_err == 0)
      t_err = $time;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // gap: 0 back-to-back, 1 toggle, 2 random
  task automatic drive(input int gap);
    bit acc;
    acc_n = 0;
    t_run = 0;
    t_err = 0;
    t_acc = 0;
    got_a.delete();
    got_d.delete();
    got_at.delete();
    foreach (stim[i]) begin
      if ((gap == 1 && i > 0) ||
          (gap == 2 && $urandom_range(1) == 1)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = stim[i];
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) begin
        acc_n++;
        t_acc = $time;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic set_basic(input logic [7:0] chk);
    stim = '{8'h00, 8'h02, 8'h20, 8'h08,
             8'h00, 8'h05, 8'h00, 8'h00,
             8'h00, 8'h00, chk};
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    if (n <= 256) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x ^= b;
        stim.push_back(b);
      end
      if (bad) x ^= 8'($urandom_range(255, 1));
      stim.push_back(x);
    end else begin
      stim.push_back(8'h55);
      stim.push_back(8'hAA);
    end
  endtask

  // Reference: parse the stream as a whole
  task automatic model();
    int n;
    logic [7:0] x;
    ex_a.delete();
    ex_d.delete();
    ex_at.delete();
    ex_run = 1'b0;
    ex_err = 1'b0;
    n = int'({stim[0], stim[1]});
    if (n > 256) begin
      ex_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      ex_a.push_back(32'(4 * k));
      ex_d.push_back({stim[2+4*k], stim[3+4*k],
                      stim[4+4*k], stim[5+4*k]});
      ex_at.push_back(4 * k + 6);
      for (int j = 0; j < 4; j++)
        x ^= stim[2+4*k+j];
    end
    if (stim[2+4*n] == x) ex_run = 1'b1;
    else ex_err = 1'b1;
  endtask

  task automatic test_basic();
    set_basic(8'h2D);
    do_reset();
    drive(0);
    checks++;
    if (core_run !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_run: run=%b err=%b exp 1 0",
               core_run, load_err);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_a.size() != 2) begin
      errors++;
      $display("FAIL basic_nwr: got %0d exp 2",
               got_a.size());
    end
    checks++;
    if (got_a[0] !== 32'h0 ||
        got_d[0] !== 32'h20080005 ||
        got_at[0] != 6) begin
      errors++;
      $display("FAIL basic_w0: %h %h @%0d exp 0 20080005 @6",
               got_a[0], got_d[0], got_at[0]);
    end
    checks++;
    if (got_a[1] !== 32'h4 || got_d[1] !== 32'h0 ||
        got_at[1] != 10) begin
      errors++;
      $display("FAIL basic_w1: %h %h @%0d exp 4 0 @10",
               got_a[1], got_d[1], got_at[1]);
    end
    checks++;
    if (words_loaded !== 16'd2 || bus.in_ready !== 1'b0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: wl=%0d rdy=%b busy=%b exp 2 0 0",
               words_loaded, bus.in_ready, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_we, core_run, load_err, busy,
         bus.in_ready} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags: we/run/err/busy/rdy=%b exp 00000",
               {bus.mem_we, core_run, load_err, busy,
                bus.in_ready});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 ||
        words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL rst_regs: addr=%h wdata=%h wl=%0d exp 0 0 0",
               bus.mem_addr, bus.mem_wdata, words_loaded);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_bad_chk();
    set_basic(8'h2C);
    do_reset();
    drive(0);
    repeat (2) @(negedge clk);
    checks++;
    if (got_a.size() != 2 || got_d[0] !== 32'h20080005 ||
        got_a[1] !== 32'h4) begin
      errors++;
      $display("FAIL badchk_wr: n=%0d d0=%h a1=%h exp 2 20080005 4",
               got_a.size(), got_d[0], got_a[1]);
    end
    checks++;
    if (load_err !== 1'b1 || core_run !== 1'b0 ||
        bus.in_ready !== 1'b0 || t_err - t_acc != 5) begin
      errors++;
      $display("FAIL badchk_end: err=%b run=%b rdy=%b dt=%0t exp 1 0 0 5",
               load_err, core_run, bus.in_ready, t_err - t_acc);
    end
  endtask

  task automatic test_zero();
    stim = '{8'h00, 8'h00, 8'h00};
    do_reset();
    drive(0);
    checks++;
    if (core_run !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_run: run=%b err=%b exp 1 0",
               core_run, load_err);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_a.size() != 0 || words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL zero_wr: n=%0d wl=%0d exp 0 0",
               got_a.size(), words_loaded);
    end
  endtask

  task automatic test_too_long();
    stim = '{8'h01, 8'h01};
    do_reset();
    drive(0);
    checks++;
    if (load_err !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL long_err: err=%b rdy=%b exp 1 0",
               load_err, bus.in_ready);
    end
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    drive(0);
    repeat (2) @(negedge clk);
    checks++;
    if (acc_n != 0 || got_a.size() != 0 ||
        words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL long_ign: acc=%0d wr=%0d wl=%0d exp 0 0 0",
               acc_n, got_a.size(), words_loaded);
    end
    checks++;
    if (load_err !== 1'b1 || core_run !== 1'b0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL long_end: err=%b run=%b busy=%b exp 1 0 0",
               load_err, core_run, busy);
    end
  endtask

  task automatic test_gaps();
    set_basic(8'h2D);
    do_reset();
    drive(1);
    checks++;
    if (core_run !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL gaps_run: run=%b err=%b exp 1 0",
               core_run, load_err);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_a.size() != 2 || got_a[0] !== 32'h0 ||
        got_d[0] !== 32'h20080005 || got_at[0] != 6 ||
        got_a[1] !== 32'h4 || got_d[1] !== 32'h0 ||
        got_at[1] != 10 || words_loaded !== 16'd2) begin
      errors++;
      $display("FAIL gaps_wr: n=%0d a0=%h d0=%h a1=%h d1=%h wl=%0d",
               got_a.size(), got_a[0], got_d[0],
               got_a[1], got_d[1], words_loaded);
    end
  endtask

  task automatic test_reset_mid();
    set_basic(8'h2D);
    stim = stim[0:4];
    do_reset();
    drive(0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b exp 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_we, core_run, load_err, busy,
         bus.in_ready} !== 5'b0 ||
        words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst: flags=%b wl=%0d exp 00000 0",
               {bus.mem_we, core_run, load_err, busy,
                bus.in_ready}, words_loaded);
    end
    rst_n = 1'b1;
    set_basic(8'h2D);
    drive(0);
    repeat (2) @(negedge clk);
    checks++;
    if (got_a.size() != 2 || got_a[0] !== 32'h0 ||
        got_d[0] !== 32'h20080005 ||
        core_run !== 1'b1) begin
      errors++;
      $display("FAIL mid_reload: n=%0d a0=%h d0=%h run=%b",
               got_a.size(), got_a[0], got_d[0], core_run);
    end
  endtask

  task automatic test_random();
    int  n;
    bit  bad;
    int  gap;
    time dt;
    for (int it = 0; it < 24; it++) begin
      if (it == 0) n = 256;
      else if (it == 1) n = 257;
      else if ($urandom_range(4) == 0)
        n = int'($urandom_range(300, 257));
      else n = int'($urandom_range(6));
      bad = ($urandom_range(2) == 0);
      gap = int'($urandom_range(2));
      build(n, bad);
      model();
      do_reset();
      drive(gap);
      repeat (3) @(negedge clk);
      checks++;
      if (got_a.size() != ex_a.size()) begin
        errors++;
        $display("FAIL rand%0d_nwr: got %0d exp %0d",
                 it, got_a.size(), ex_a.size());
      end else begin
        foreach (ex_a[k]) begin
          checks++;
          if (got_a[k] !== ex_a[k] ||
              got_d[k] !== ex_d[k] ||
              got_at[k] != ex_at[k]) begin
            errors++;
            $display("FAIL rand%0d_w%0d: %h %h @%0d exp %h %h @%0d",
                     it, k, got_a[k], got_d[k], got_at[k],
                     ex_a[k], ex_d[k], ex_at[k]);
          end
        end
      end
      checks++;
      if ({core_run, load_err, busy, bus.in_ready} !==
          {ex_run, ex_err, 2'b00} ||
          words_loaded !== 16'(ex_a.size())) begin
        errors++;
        $display("FAIL rand%0d_end: run=%b err=%b busy=%b rdy=%b wl=%0d exp %b %b 0 0 %0d",
                 it, core_run, load_err, busy, bus.in_ready,
                 words_loaded, ex_run, ex_err, ex_a.size());
      end
      dt = (ex_run ? t_run : t_err) - t_acc;
      checks++;
      if (dt != 5) begin
        errors++;
        $display("FAIL rand%0d_lat: flag rose %0t after last accept exp 5",
                 it, dt);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    test_basic();
    test_reset();
    test_bad_chk();
    test_zero();
    test_too_long();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
